// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups every signal of the two-cache / one-memory arbiter.
//   r0_* / r1_*   : cache-side ports (requests, address, write data in;
//                   read_ready / write_done strobes and broadcast r_rdata out)
//   M*            : single shared memory port
//   grant, grant_cnt0/1, timeout_err : status
//   dbg_state     : FSM state (0 IDLE, 1 GRANT0, 2 GRANT1, 3 TURN)
// Handshake: a cache holds read_req/write_req (and addr/wdata) at a steady
// level until it sees its own read_ready/write_done, then drops the request.
// The memory answers with MRead_ready/MWrite_done; these are forwarded only
// to the port that currently holds the grant.
// Modports: master = the arbiter, slave = the caches plus memory around it.
interface mem_arbiter_if;
  logic        r0_read_req, r1_read_req;
  logic        r0_write_req, r1_write_req;
  logic [7:0]  r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic        r0_read_ready, r1_read_ready;
  logic        r0_write_done, r1_write_done;
  logic [31:0] r_rdata;
  logic        MRead_request, MWrite_request;
  logic [7:0]  MAddress, MWrite_data;
  logic [31:0] MRead_data;
  logic        MRead_ready, MWrite_done;
  logic [1:0]  grant;
  logic [7:0]  grant_cnt0, grant_cnt1;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  modport master (
    input  r0_read_req, r1_read_req, r0_write_req, r1_write_req,
           r0_addr, r1_addr, r0_wdata, r1_wdata,
           MRead_data, MRead_ready, MWrite_done,
    output r0_read_ready, r1_read_ready, r0_write_done, r1_write_done, r_rdata,
           MRead_request, MWrite_request, MAddress, MWrite_data,
           grant, grant_cnt0, grant_cnt1, timeout_err, dbg_state
  );

  modport slave (
    output r0_read_req, r1_read_req, r0_write_req, r1_write_req,
           r0_addr, r1_addr, r0_wdata, r1_wdata,
           MRead_data, MRead_ready, MWrite_done,
    input  r0_read_ready, r1_read_ready, r0_write_done, r1_write_done, r_rdata,
           MRead_request, MWrite_request, MAddress, MWrite_data,
           grant, grant_cnt0, grant_cnt1, timeout_err, dbg_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between two caches.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_arbiter_if.master (cache ports, memory port, status)
// A grant is held for the whole transaction; after the owner releases, one
// TURN cycle keeps memory requests low before the next owner is chosen.
// A watchdog sets the sticky timeout_err when a grant waits TIMEOUT cycles
// without MRead_ready/MWrite_done.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t     state_q, state_d;
  logic       last_grant_q;
  logic [7:0] grant_cnt0_q, grant_cnt1_q;
  logic [7:0] wait_cnt_q;
  logic       timeout_err_q;

  logic       req0, req1;
  logic       enter0, enter1;
  logic       in_grant, mem_strobe;
  logic [8:0] wait_inc;

  assign req0       = bus.r0_read_req | bus.r0_write_req;
  assign req1       = bus.r1_read_req | bus.r1_write_req;
  assign enter0     = (state_q == IDLE) && (state_d == GRANT0);
  assign enter1     = (state_q == IDLE) && (state_d == GRANT1);
  assign in_grant   = (state_q == GRANT0) || (state_q == GRANT1);
  assign mem_strobe = bus.MRead_ready | bus.MWrite_done;
  assign wait_inc   = {1'b0, wait_cnt_q} + 9'd1;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_grant_q ? GRANT0 : GRANT1;
        else if (req0)    state_d = GRANT0;
        else if (req1)    state_d = GRANT1;
      end
      GRANT0:  if (!req0) state_d = TURN;
      GRANT1:  if (!req1) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Routing: everything is zero unless a port holds the grant. Read wins
  // over a simultaneous write request from the same port.
  always_comb begin
    bus.MRead_request  = 1'b0;
    bus.MWrite_request = 1'b0;
    bus.MAddress       = 8'h00;
    bus.MWrite_data    = 8'h00;
    bus.r0_read_ready  = 1'b0;
    bus.r1_read_ready  = 1'b0;
    bus.r0_write_done  = 1'b0;
    bus.r1_write_done  = 1'b0;
    bus.grant          = 2'b00;
    case (state_q)
      GRANT0: begin
        bus.MRead_request  = bus.r0_read_req;
        bus.MWrite_request = bus.r0_write_req & ~bus.r0_read_req;
        bus.MAddress       = bus.r0_addr;
        bus.MWrite_data    = bus.r0_wdata;
        bus.r0_read_ready  = bus.MRead_ready;
        bus.r0_write_done  = bus.MWrite_done;
        bus.grant          = 2'b01;
      end
      GRANT1: begin
        bus.MRead_request  = bus.r1_read_req;
        bus.MWrite_request = bus.r1_write_req & ~bus.r1_read_req;
        bus.MAddress       = bus.r1_addr;
        bus.MWrite_data    = bus.r1_wdata;
        bus.r1_read_ready  = bus.MRead_ready;
        bus.r1_write_done  = bus.MWrite_done;
        bus.grant          = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.r_rdata     = bus.MRead_data;
  assign bus.grant_cnt0  = grant_cnt0_q;
  assign bus.grant_cnt1  = grant_cnt1_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_cnt0_q  <= 8'h00;
      grant_cnt1_q  <= 8'h00;
      wait_cnt_q    <= 8'h00;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter0) begin
        last_grant_q <= 1'b0;
        if (grant_cnt0_q != 8'hFF) grant_cnt0_q <= grant_cnt0_q + 8'd1;
      end
      if (enter1) begin
        last_grant_q <= 1'b1;
        if (grant_cnt1_q != 8'hFF) grant_cnt1_q <= grant_cnt1_q + 8'd1;
      end
      // The flag is raised on the same edge the count reaches TIMEOUT.
      if (enter0 || enter1) begin
        wait_cnt_q <= 8'h00;
      end else if (in_grant) begin
        if (mem_strobe) begin
          wait_cnt_q <= 8'h00;
        end else begin
          if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_inc[7:0];
          if (wait_inc >= TIMEOUT_W) timeout_err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares a single 8-bit-address / 32-bit-read-data memory port between two direct-mapped caches (e.g. instruction and data cache). Each port presents the same memory-side interface a cache drives (read/write request, address, write data, ready/done). The arbiter grants one port at a time and holds the grant for the whole transaction, including the requester's release. It routes that port's signals to memory, returns the completion strobe only to the granted port, and keeps per-port grant statistics plus a stall watchdog.

## Interface
- TIMEOUT, 255: cycles a grant may wait for MRead_ready/MWrite_done before timeout_err sets (1..255).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- r0_read_req, r1_read_req  in  1  port read request (level, held until ready seen).
- r0_write_req, r1_write_req  in  1  port write request (level).
- r0_addr, r1_addr  in  8  port memory address.
- r0_wdata, r1_wdata  in  8  port write data.
- r0_read_ready, r1_read_ready  out  1  MRead_ready gated to granted port.
- r0_write_done, r1_write_done  out  1  MWrite_done gated to granted port.
- r_rdata  out  32  MRead_data broadcast to both ports (valid only with that port's read_ready).
- MRead_request, MWrite_request  out  1  to memory.
- MAddress, MWrite_data  out  8  to memory.
- MRead_data  in  32; MRead_ready, MWrite_done  in  1  from memory.
- grant  out  2  one-hot current owner ({r1,r0}); 2'b00 when idle.
- grant_cnt0, grant_cnt1  out  8  saturating grants issued per port.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- Port n "requesting" = rn_read_req | rn_write_req. If both bits are high, read wins: write is not forwarded.
- States: IDLE, GRANT0, GRANT1, TURN.
- IDLE: neither requesting -> stay. One requesting -> GRANTn. Both requesting -> grant the port that is not last_grant. On entry to GRANTn: last_grant <= n, grant_cnt_n increments (saturates at 255).
- GRANTn: memory outputs driven combinationally from port n (MRead_request = rn_read_req, MWrite_request = rn_write_req & ~rn_read_req, MAddress = rn_addr, MWrite_data = rn_wdata). rn_read_ready = MRead_ready and rn_write_done = MWrite_done; the other port's strobes are 0. Stay while port n is requesting. Go to TURN the cycle after port n drops both requests.
- A port that switches read->write without a low cycle keeps its grant; it is treated as one continuous transaction.
- TURN: one mandatory cycle with all memory requests low, so memory sees a deassertion between owners. Then go to IDLE.
- Outside GRANTn: MRead_request = MWrite_request = 0, MAddress = MWrite_data = 0, all port strobes 0, grant = 0.
- Watchdog: wait_cnt clears on entry to GRANTn and whenever MRead_ready|MWrite_done is high. It increments otherwise while in GRANTn. When it reaches TIMEOUT, timeout_err <= 1. The flag clears only on rst. The grant is not revoked.
- Memory strobes arriving outside GRANTn are ignored.

## Timing
- Reset values: state IDLE, last_grant = 1 (port 0 wins the first tie), grant 0, grant counts 0, wait_cnt 0, timeout_err 0. All memory and port outputs are 0.
- rst during GRANTn aborts the grant: memory request drops in the cycle after the reset edge. Pending requesters re-arbitrate after reset releases.
- Latency: request high in IDLE at edge k -> grant and memory request visible in cycle k+1.
- Release: request low sampled at edge m -> TURN in cycle m+1, IDLE in m+2. A waiting request is granted at edge m+2 and visible in cycle m+3, giving a 2-cycle gap between owners.
- Back-to-back requests from the same port with the other idle follow the same path: TURN, IDLE, then GRANT again.
- Ready/done pass through combinationally, with zero added latency.
- Counters are 8-bit and saturating; there is no wrap.

## Test plan
- Single read, port 0: r0_read_req=1, r0_addr=0x2D. Expect MRead_request=1 and MAddress=0x2D one cycle later. Memory returns ready with data 0xDEADBEEF -> r0_read_ready=1, r_rdata=0xDEADBEEF, r1_read_ready=0. After release, grant_cnt0=1.
- Simultaneous requests after reset: r0 read and r1 write at the same edge. Expect port 0 granted first. After port 0 releases, one TURN cycle with MRead_request=MWrite_request=0, then GRANT1 with MAddress=r1_addr and MWrite_data=r1_wdata.
- Fairness: both ports requesting continuously for 6 transactions. Expect grant order 0,1,0,1,0,1 and grant_cnt0=grant_cnt1=3.
- Write routing: r1_write_req=1, r1_addr=0x80, r1_wdata=0x5A. Expect MWrite_request=1 with MAddress=0x80 and MWrite_data=0x5A. MWrite_done -> r1_write_done=1 and r0_write_done=0.
- Watchdog at TIMEOUT=4: grant port 0, memory silent. Expect timeout_err=1 after 4 cycles in GRANT0. The flag remains set after the ready and release, and clears only on rst.
- Reset mid-grant and saturation: assert rst during GRANT1 -> all outputs 0 the next cycle and counts 0. Then perform 260 port-0 grants -> grant_cnt0=255.
